// File: rtl/wb_commit_serializer.sv
// rtl/wb_commit_serializer.sv - dual-issue writeback to single-lane debug trace serializer
// Optional commit/drop counters are enabled by defining WB_COMMIT_CNT_EN.
module wb_commit_serializer #(
  parameter int DEPTH     = 8,
  parameter int FILTER_R0 = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb0_en,
  input  logic [4:0]  wb0_rd,
  input  logic [31:0] wb0_wdata,
  input  logic [31:0] wb0_pc,
  input  logic        wb1_en,
  input  logic [4:0]  wb1_rd,
  input  logic [31:0] wb1_wdata,
  input  logic [31:0] wb1_pc,
  output logic        in_ready,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
  output logic        overflow,
  output logic        empty
`ifdef WB_COMMIT_CNT_EN
  ,
  output logic [31:0] commit_cnt,
  output logic [15:0] drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc_mem [DEPTH];
  logic [4:0]    rd_mem [DEPTH];
  logic [31:0]   wd_mem [DEPTH];

  logic [AW-1:0] head, tail, tail_p1;
  logic [CW-1:0] count, count_nxt;
  logic          v0, v1, any_v, enq, deq, drop;
  logic [1:0]    n_valid;

  assign v0      = wb0_en && !((FILTER_R0 != 0) && (wb0_rd == 5'd0));
  assign v1      = wb1_en && !((FILTER_R0 != 0) && (wb1_rd == 5'd0));
  assign any_v   = v0 || v1;
  assign n_valid = {1'b0, v0} + {1'b0, v1};
  assign tail_p1 = tail + AW'(1);

  // Two free slots guarantee a dual write always fits; depends on registered count only.
  assign in_ready = (count <= CW'(DEPTH - 2));
  assign empty    = (count == '0);
  assign enq      = in_ready && any_v;
  assign drop     = !in_ready && any_v;
  assign deq      = (count != '0);

  always_comb begin
    count_nxt = count;
    if (enq) count_nxt = count_nxt + CW'(n_valid);
    if (deq) count_nxt = count_nxt - CW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      overflow          <= 1'b0;
      debug_wb_pc       <= '0;
      debug_wb_rf_wen   <= 4'h0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
    end else begin
      count <= count_nxt;
      if (enq) tail <= tail + AW'(n_valid);
      if (drop) overflow <= 1'b1;
      if (deq) begin
        head              <= head + AW'(1);
        debug_wb_pc       <= pc_mem[head];
        debug_wb_rf_wen   <= 4'hf;
        debug_wb_rf_wnum  <= rd_mem[head];
        debug_wb_rf_wdata <= wd_mem[head];
      end else begin
        // PC is left at the last commit so the trace keeps a stable reference.
        debug_wb_rf_wen   <= 4'h0;
        debug_wb_rf_wnum  <= '0;
        debug_wb_rf_wdata <= '0;
      end
    end
  end

  // The oldest valid slot always lands at tail; slot 1 follows only on a dual write.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[tail] <= v0 ? wb0_pc    : wb1_pc;
      rd_mem[tail] <= v0 ? wb0_rd    : wb1_rd;
      wd_mem[tail] <= v0 ? wb0_wdata : wb1_wdata;
      if (v0 && v1) begin
        pc_mem[tail_p1] <= wb1_pc;
        rd_mem[tail_p1] <= wb1_rd;
        wd_mem[tail_p1] <= wb1_wdata;
      end
    end
  end

`ifdef WB_COMMIT_CNT_EN
  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, drop_cnt} + 17'(n_valid);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      commit_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (deq)  commit_cnt <= commit_cnt + 32'd1;
      if (drop) drop_cnt   <= drop_sum[16] ? 16'hffff : drop_sum[15:0];
    end
  end
`endif

endmodule
